// File: rtl/midi_pkg.sv
// Shared MIDI definitions used by the serial receiver and the command decoder.
//   MIDI_BAUD / MIDI_OVERSAMPLE : line rate and sample ticks per bit
//   rx_state_t                  : receiver FSM encoding (3 bits)
//   MIDI_STATUS_MASK            : bit that marks a status byte
//   MIDI_RESET_CMD              : system reset command byte
//   majority3()                 : 2-of-3 vote used for bit sampling
package midi_pkg;

  localparam int MIDI_BAUD       = 31250;
  localparam int MIDI_OVERSAMPLE = 16;

  localparam logic [7:0] MIDI_STATUS_MASK = 8'h80;
  localparam logic [7:0] MIDI_RESET_CMD   = 8'hFF;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/midi_uart_rx_if.sv
// Receiver-side bundle between the MIDI line, the UART receiver and its consumer.
//   midi_in    : raw serial line, idle high (driven by the line side)
//   valid_byte : one-cycle pulse, data holds a new byte
//   data       : last good byte, stable until the next valid_byte
//   frame_err  : one-cycle pulse, stop bit sampled low
//   err_count  : saturating frame error count
//   busy       : receiver is inside a frame
//   state_dbg  : receiver FSM state, for debug visibility
// Handshake: valid_byte is a single-cycle strobe with no ready; the consumer
// must accept data in the cycle valid_byte is high. data stays valid after.
// master = receiver, slave = line driver / byte consumer.
interface midi_uart_rx_if;
  import midi_pkg::*;

  logic       midi_in;
  logic       valid_byte;
  logic [7:0] data;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;
  rx_state_t  state_dbg;

  modport master (
    input  midi_in,
    output valid_byte, data, frame_err, err_count, busy, state_dbg
  );

  modport slave (
    output midi_in,
    input  valid_byte, data, frame_err, err_count, busy, state_dbg
  );

endinterface

// File: rtl/midi_baud_tick.sv
// Oversampling tick generator.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count so the next tick lands DIV clocks later
//   tick       : high for one clock when the counter reaches DIV-1
module midi_baud_tick #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver, 8N1, LSB first, idle-high line.
//   clk    : system clock
//   rst_n  : async active-low reset (released synchronously inside)
//   rx_if  : midi_uart_rx_if.master (midi_in in; valid_byte, data,
//            frame_err, err_count, busy, state_dbg out)
// Each bit is sampled at oversample ticks 7, 8 and 9 and voted 2-of-3.
// A low stop bit discards the byte and parks the FSM in RX_BREAK until the
// line has been high for a full bit, so a held-low line reports one error.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int OVERSAMPLE = MIDI_OVERSAMPLE
) (
  input  logic           clk,
  input  logic           rst_n,
  midi_uart_rx_if.master rx_if
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  // Reset: asserts immediately, deasserts two clocks after rst_n rises.
  logic rst_meta_q, rst_sync_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  logic       sync1_q, sync2_q, prev_q;
  rx_state_t  state_q;
  logic [3:0] samp_cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       s7_q, s8_q;
  logic       valid_q, frame_err_q, busy_q;
  logic [7:0] data_q, err_cnt_q;

  logic fall, tick, tick_clear, maj, mid_bit, in_frame;

  assign fall       = prev_q & ~sync2_q;
  assign tick_clear = (state_q == RX_IDLE) && fall;
  // Third vote is the live synced value at tick 9.
  assign maj        = majority3(s7_q, s8_q, sync2_q);
  assign mid_bit    = tick && (samp_cnt_q == 4'd9);
  assign in_frame   = (state_q == RX_START) || (state_q == RX_DATA) || (state_q == RX_STOP);

  midi_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_sync_n_q),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= RX_IDLE;
      samp_cnt_q  <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= 8'h00;
      err_cnt_q   <= 8'h00;
    end else begin
      sync1_q     <= rx_if.midi_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      // Shared sampling for all in-frame states; the counter wraps every bit.
      if (in_frame && tick) begin
        samp_cnt_q <= samp_cnt_q + 4'd1;
        if (samp_cnt_q == 4'd7) s7_q <= sync2_q;
        if (samp_cnt_q == 4'd8) s8_q <= sync2_q;
      end

      unique case (state_q)
        RX_IDLE: begin
          if (fall) begin
            state_q    <= RX_START;
            busy_q     <= 1'b1;
            samp_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
          end
        end

        RX_START: begin
          if (mid_bit) begin
            if (!maj) begin
              state_q <= RX_DATA;
            end else begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        RX_DATA: begin
          if (mid_bit) begin
            shift_q <= {maj, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end

        RX_STOP: begin
          if (mid_bit) begin
            if (maj) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              state_q    <= RX_BREAK;
              samp_cnt_q <= 4'd0;
            end
          end
        end

        RX_BREAK: begin
          // Any low sample restarts the one-bit high qualification.
          if (!sync2_q) begin
            samp_cnt_q <= 4'd0;
          end else if (tick) begin
            samp_cnt_q <= samp_cnt_q + 4'd1;
            if (samp_cnt_q == 4'd15) begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.valid_byte = valid_q;
  assign rx_if.data       = data_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.err_count  = err_cnt_q;
  assign rx_if.busy       = busy_q;
  assign rx_if.state_dbg  = state_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx. Time unit treated as ns. The DUT runs from a 5 MHz
// clock (CLK_FREQ overridden, DIV=10) so a 5 ms break stays short in cycles;
// the line is still driven at 32 us per bit.
module tb_midi_uart_rx;
  import midi_pkg::*;

  localparam int CLK_HALF = 100;
  localparam int BIT_T    = 32000;
  localparam int BIT_FAST = 31360;   // baud +2 %
  localparam int BIT_SLOW = 32640;   // baud -2 %

  logic clk;
  logic rst_n;

  midi_uart_rx_if bus_if ();

  midi_uart_rx #(
    .CLK_FREQ   (5_000_000),
    .BAUD       (31250),
    .OVERSAMPLE (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(CLK_HALF) clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks      = 0;
  int errors      = 0;
  int valid_count = 0;
  int fe_count    = 0;

  always @(negedge clk) begin
    if (bus_if.valid_byte === 1'b1) begin
      logic [7:0] exp_b;
      valid_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid data=%h expected no byte", bus_if.data);
      end else begin
        exp_b = exp_q.pop_front();
        if (bus_if.data !== exp_b) begin
          errors++;
          $display("FAIL scoreboard_data got=%h exp=%h", bus_if.data, exp_b);
        end
      end
    end
    if (bus_if.frame_err === 1'b1) fe_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bits(input int n, input int bit_t);
    bus_if.midi_in = 1'b1;
    #(n * bit_t);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop, input int bit_t);
    if (good_stop) exp_q.push_back(b);
    bus_if.midi_in = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      bus_if.midi_in = b[i];
      #(bit_t);
    end
    bus_if.midi_in = good_stop ? 1'b1 : 1'b0;
    #(bit_t);
    bus_if.midi_in = 1'b1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got=%0d bytes outstanding exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.midi_in = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus_if.valid_byte, bus_if.frame_err, bus_if.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000",
               {bus_if.valid_byte, bus_if.frame_err, bus_if.busy});
    end
    checks++;
    if (bus_if.data !== 8'h00 || bus_if.err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs got data=%h cnt=%h exp 00 00", bus_if.data, bus_if.err_count);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus_if.state_dbg !== RX_IDLE || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got state=%0d busy=%b exp 0 0", bus_if.state_dbg, bus_if.busy);
    end
    idle_bits(2, BIT_T);
  endtask

  task automatic test_basic_bytes();
    int v0 = valid_count;
    send_byte(8'h90, 1'b1, BIT_T); idle_bits(1, BIT_T);
    send_byte(8'h3C, 1'b1, BIT_T); idle_bits(1, BIT_T);
    send_byte(8'h64, 1'b1, BIT_T); idle_bits(1, BIT_T);
    check_drained("basic");
    checks++;
    if (valid_count - v0 != 3 || fe_count != 0) begin
      errors++;
      $display("FAIL basic_counts got valid=%0d fe=%0d exp 3 0", valid_count - v0, fe_count);
    end
  endtask

  task automatic test_frame_error();
    int v0  = valid_count;
    int fe0 = fe_count;
    send_byte(8'hA5, 1'b0, BIT_T);
    idle_bits(2, BIT_T);
    checks++;
    if (fe_count - fe0 != 1 || bus_if.err_count !== 8'd1) begin
      errors++;
      $display("FAIL frame_err got pulses=%0d cnt=%0d exp 1 1", fe_count - fe0, bus_if.err_count);
    end
    checks++;
    if (valid_count != v0 || bus_if.data !== 8'h64) begin
      errors++;
      $display("FAIL frame_err_data got valid=%0d data=%h exp 0 64", valid_count - v0, bus_if.data);
    end
    send_byte(8'h80, 1'b1, BIT_T);
    idle_bits(1, BIT_T);
    check_drained("after_frame_err");
  endtask

  task automatic test_glitch();
    int v0  = valid_count;
    int fe0 = fe_count;
    bus_if.midi_in = 1'b0;
    #1000;
    bus_if.midi_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_detect got busy=%b exp 1", bus_if.busy);
    end
    for (int i = 0; i < 160 && bus_if.busy === 1'b1; i++) @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.state_dbg !== RX_IDLE) begin
      errors++;
      $display("FAIL glitch_release got busy=%b state=%0d exp 0 0", bus_if.busy, bus_if.state_dbg);
    end
    idle_bits(1, BIT_T);
    checks++;
    if (valid_count != v0 || fe_count != fe0) begin
      errors++;
      $display("FAIL glitch_output got valid=%0d fe=%0d exp 0 0", valid_count - v0, fe_count - fe0);
    end
  endtask

  task automatic test_break();
    int v0  = valid_count;
    int fe0 = fe_count;
    bus_if.midi_in = 1'b0;
    #5_000_000;
    idle_bits(3, BIT_T);
    checks++;
    if (fe_count - fe0 != 1 || bus_if.err_count !== 8'd2 || bus_if.data !== 8'h80) begin
      errors++;
      $display("FAIL break_err got pulses=%0d cnt=%0d data=%h exp 1 2 80",
               fe_count - fe0, bus_if.err_count, bus_if.data);
    end
    send_byte(8'hFF, 1'b1, BIT_T);
    idle_bits(1, BIT_T);
    check_drained("break");
    checks++;
    if (valid_count - v0 != 1 || fe_count - fe0 != 1) begin
      errors++;
      $display("FAIL break_counts got valid=%0d fe=%0d exp 1 1", valid_count - v0, fe_count - fe0);
    end
  endtask

  task automatic test_back_to_back();
    int v0  = valid_count;
    int fe0 = fe_count;
    int rates[2] = '{BIT_FAST, BIT_SLOW};
    logic [7:0] seq[3] = '{8'h00, 8'hFF, 8'h55};
    foreach (rates[r]) begin
      foreach (seq[k]) send_byte(seq[k], 1'b1, rates[r]);
      idle_bits(2, BIT_T);
      check_drained(r == 0 ? "b2b_fast" : "b2b_slow");
    end
    checks++;
    if (valid_count - v0 != 6 || fe_count != fe0) begin
      errors++;
      $display("FAIL b2b_counts got valid=%0d fe=%0d exp 6 0", valid_count - v0, fe_count - fe0);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b = 8'h3C;
    int v0 = valid_count;
    bus_if.midi_in = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      bus_if.midi_in = b[i];
      #(BIT_T);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.data !== 8'h00 || bus_if.err_count !== 8'h00) begin
      errors++;
      $display("FAIL midreset_regs got busy=%b data=%h cnt=%h exp 0 00 00",
               bus_if.busy, bus_if.data, bus_if.err_count);
    end
    bus_if.midi_in = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2, BIT_T);
    checks++;
    if (valid_count != v0) begin
      errors++;
      $display("FAIL midreset_aborted got valid=%0d exp 0", valid_count - v0);
    end
    send_byte(8'h3C, 1'b1, BIT_T);
    idle_bits(1, BIT_T);
    check_drained("midreset");
    checks++;
    if (bus_if.data !== 8'h3C || bus_if.err_count !== 8'h00) begin
      errors++;
      $display("FAIL midreset_final got data=%h cnt=%h exp 3C 00", bus_if.data, bus_if.err_count);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_bytes();
    test_frame_error();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
